// File: rtl/int_img_pkg.sv
// Shared types and defaults for the integral-image frame sequencer and the window scanner.
package int_img_pkg;

  localparam int unsigned DEF_WIDTH_LIMIT  = 24;
  localparam int unsigned DEF_HEIGHT_LIMIT = 24;

  localparam int unsigned DEF_SETTLE_CYCLES = 16;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DEF_ROW_W = idx_width(DEF_HEIGHT_LIMIT);
  localparam int unsigned DEF_COL_W = idx_width(DEF_WIDTH_LIMIT);

  typedef logic [DEF_ROW_W-1:0] row_idx_t;
  typedef logic [DEF_COL_W-1:0] col_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SETTLE,
    READY
  } frame_state_t;

endpackage

// File: rtl/int_img_frame_ctrl_raster_addr_counter.sv
// Raster row/col counter: wraps col into row, flags the last pixel, supports clear and restart-at-(0,1).
module raster_addr_counter
  import int_img_pkg::*;
#(
  parameter int unsigned WIDTH_LIMIT  = DEF_WIDTH_LIMIT,
  parameter int unsigned HEIGHT_LIMIT = DEF_HEIGHT_LIMIT
) (
  input  logic                                 clock,
  input  logic                                 reset_n,
  input  logic                                 clear,
  input  logic                                 load_one,
  input  logic                                 advance,
  output logic [idx_width(HEIGHT_LIMIT)-1:0]   row,
  output logic [idx_width(WIDTH_LIMIT)-1:0]    col,
  output logic                                 last
);

  localparam int unsigned ROW_W = idx_width(HEIGHT_LIMIT);
  localparam int unsigned COL_W = idx_width(WIDTH_LIMIT);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT_LIMIT - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH_LIMIT - 1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (load_one) begin
      row <= '0;
      col <= COL_W'(1);
    end else if (advance) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  assign last = (row == ROW_LAST) && (col == COL_LAST);

endmodule

// File: rtl/int_img_frame_ctrl.sv
// Captures a raster frame for the combinational integral-image array, waits out its settle
// window, then presents int_valid until the window scanner acknowledges.
module int_img_frame_ctrl
  import int_img_pkg::*;
#(
  parameter int unsigned WIDTH_LIMIT   = DEF_WIDTH_LIMIT,
  parameter int unsigned HEIGHT_LIMIT  = DEF_HEIGHT_LIMIT,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic                                  clock,
  input  logic                                  reset_n,
  input  logic [7:0]                            pix_data,
  input  logic                                  pix_valid,
  input  logic                                  pix_sof,
  output logic                                  pix_ready,
  output logic [HEIGHT_LIMIT*WIDTH_LIMIT*8-1:0] frame_img,
  output logic                                  int_valid,
  input  logic                                  int_ack,
  output logic                                  busy,
  output logic                                  overrun
);

  localparam int unsigned NPIX  = HEIGHT_LIMIT * WIDTH_LIMIT;
  localparam int unsigned ROW_W = idx_width(HEIGHT_LIMIT);
  localparam int unsigned COL_W = idx_width(WIDTH_LIMIT);
  localparam int unsigned AW    = idx_width(NPIX);
  localparam int unsigned SW    = idx_width(SETTLE_CYCLES);

  frame_state_t      state_q, state_d;
  logic [SW-1:0]     settle_q, settle_d;
  logic              pix_ready_q, int_valid_q, overrun_q, overrun_d;
  logic [NPIX*8-1:0] frame_q;
  logic [ROW_W-1:0]  row;
  logic [COL_W-1:0]  col;
  logic              last;
  logic              accept;
  logic              cnt_clear, cnt_load_one, cnt_advance;
  logic              wr_en, wr_at_origin;
  logic [AW-1:0]     wr_idx;

  raster_addr_counter #(
    .WIDTH_LIMIT  (WIDTH_LIMIT),
    .HEIGHT_LIMIT (HEIGHT_LIMIT)
  ) u_addr (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (cnt_clear),
    .load_one (cnt_load_one),
    .advance  (cnt_advance),
    .row      (row),
    .col      (col),
    .last     (last)
  );

  assign accept = pix_valid & pix_ready_q;

  always_comb begin
    state_d      = state_q;
    settle_d     = settle_q;
    cnt_clear    = 1'b0;
    cnt_load_one = 1'b0;
    cnt_advance  = 1'b0;
    wr_en        = 1'b0;
    wr_at_origin = 1'b0;
    overrun_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept && pix_sof) begin
          wr_en        = 1'b1;
          wr_at_origin = 1'b1;
          cnt_load_one = 1'b1;
          state_d      = LOAD;
        end
      end
      LOAD: begin
        if (accept) begin
          wr_en = 1'b1;
          if (pix_sof) begin
            wr_at_origin = 1'b1;
            cnt_load_one = 1'b1;
            overrun_d    = 1'b1;
          end else if (last) begin
            cnt_clear = 1'b1;
            settle_d  = SW'(SETTLE_CYCLES - 1);
            state_d   = SETTLE;
          end else begin
            cnt_advance = 1'b1;
          end
        end
      end
      SETTLE: begin
        if (settle_q == '0) state_d = READY;
        else                settle_d = settle_q - SW'(1);
      end
      READY: begin
        if (int_ack) state_d = IDLE;
      end
    endcase
  end

  assign wr_idx = wr_at_origin ? '0 : AW'(row) * AW'(WIDTH_LIMIT) + AW'(col);

  // Ready/valid are registered from the next state so both stay Moore outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      settle_q    <= '0;
      pix_ready_q <= 1'b0;
      int_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      frame_q     <= '0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      pix_ready_q <= (state_d == IDLE) || (state_d == LOAD);
      int_valid_q <= (state_d == READY);
      overrun_q   <= overrun_d;
      if (wr_en) frame_q[{wr_idx, 3'b000} +: 8] <= pix_data;
    end
  end

  assign pix_ready = pix_ready_q;
  assign int_valid = int_valid_q;
  assign overrun   = overrun_q;
  assign frame_img = frame_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_int_img_frame_ctrl.sv
// Scoreboard bench for int_img_frame_ctrl on a 4x3 frame, settle windows of 2 and 1 clocks.
module tb_int_img_frame_ctrl;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int NP = W * H;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [7:0]    pix_data = '0;
  logic          pix_valid = 1'b0;
  logic          pix_sof = 1'b0;
  logic          int_ack = 1'b0;
  logic          pr0, iv0, busy0, ov0, pr1, iv1, busy1, ov1;
  logic [NP*8-1:0] fi0, fi1;

  int_img_frame_ctrl #(.WIDTH_LIMIT(W), .HEIGHT_LIMIT(H), .SETTLE_CYCLES(2)) dut (
    .clock(clock), .reset_n(reset_n), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_sof(pix_sof), .pix_ready(pr0), .frame_img(fi0), .int_valid(iv0),
    .int_ack(int_ack), .busy(busy0), .overrun(ov0)
  );

  int_img_frame_ctrl #(.WIDTH_LIMIT(W), .HEIGHT_LIMIT(H), .SETTLE_CYCLES(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_sof(pix_sof), .pix_ready(pr1), .frame_img(fi1), .int_valid(iv1),
    .int_ack(int_ack), .busy(busy1), .overrun(ov1)
  );

  logic use1 = 1'b0;
  logic obs_pr, obs_iv, obs_busy, obs_ov;
  logic [NP*8-1:0] obs_fi;
  assign obs_pr   = use1 ? pr1   : pr0;
  assign obs_iv   = use1 ? iv1   : iv0;
  assign obs_busy = use1 ? busy1 : busy0;
  assign obs_ov   = use1 ? ov1   : ov0;
  assign obs_fi   = use1 ? fi1   : fi0;

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int unsigned cyc = 0;

  logic [7:0]  m_frame [NP];
  bit          m_loading, m_pending, m_ready, m_valid, m_ovr, prev_iv;
  int          m_idx;
  int unsigned m_due;
  int unsigned m_settle = 2;

  typedef struct {
    logic [NP*8-1:0] frame;
    int unsigned     due;
  } sb_t;
  sb_t sb[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [NP*8-1:0] pack_model();
    logic [NP*8-1:0] v;
    for (int i = 0; i < NP; i++) v[i*8 +: 8] = m_frame[i];
    return v;
  endfunction

  function automatic int unsigned isum(input logic [NP*8-1:0] f, input int r2, input int c2,
                                       input bit sq);
    int unsigned s = 0;
    logic [7:0] p;
    for (int r = 0; r <= r2; r++)
      for (int c = 0; c <= c2; c++) begin
        p = f[(r*W + c)*8 +: 8];
        s += sq ? p * p : p;
      end
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NP; i++) m_frame[i] = '0;
    m_loading = 0; m_pending = 0; m_ready = 0; m_valid = 0; m_ovr = 0;
    m_idx = 0; m_due = 0; prev_iv = 0;
    sb.delete();
  endtask

  task automatic observe();
    sb_t e;
    check("pix_ready", obs_pr, m_ready);
    check("int_valid", obs_iv, m_valid);
    check("busy", obs_busy, m_loading || m_pending);
    check("overrun", obs_ov, m_ovr);
    check("frame_img", obs_fi, pack_model());
    if (obs_iv && !prev_iv) begin
      if (sb.size() == 0) check("sb_extra_valid", obs_iv, 1'b0);
      else begin
        e = sb.pop_front();
        check("sb_frame", obs_fi, e.frame);
        check("sb_latency", cyc, e.due);
      end
    end
    prev_iv = obs_iv;
  endtask

  task automatic step();
    bit acc, ack;
    acc = pix_valid && m_ready;
    ack = m_valid && int_ack;
    @(posedge clock);
    cyc++;
    m_ovr = 0;
    if (ack) m_pending = 0;
    if (acc) begin
      if (pix_sof) begin
        m_ovr = m_loading;
        m_frame[0] = pix_data;
        m_idx = 1;
        m_loading = 1;
      end else if (m_loading) begin
        m_frame[m_idx] = pix_data;
        m_idx++;
        if (m_idx == NP) begin
          m_loading = 0;
          m_pending = 1;
          m_due = cyc + m_settle;
          sb.push_back('{frame: pack_model(), due: m_due});
        end
      end
    end
    m_valid = m_pending && (cyc >= m_due);
    m_ready = !m_pending;
    #1;
    observe();
  endtask

  task automatic send(input logic [7:0] d, input bit sof);
    pix_valid = 1'b1;
    pix_data  = d;
    pix_sof   = sof;
    step();
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic send_frame(input int base, input bit gap);
    for (int i = 0; i < NP; i++) begin
      send(8'(base + i), i == 0);
      if (gap) step();
    end
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!obs_iv && n < 20) begin
      step();
      n++;
    end
    if (!obs_iv) check("valid_timeout", obs_iv, 1'b1);
  endtask

  task automatic do_ack();
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
  endtask

  task automatic async_reset();
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    observe();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #3;
    observe();
    @(negedge clock);
    reset_n = 1'b1;
    step();

    // Full frame 1..12, back-to-back
    send_frame(1, 1'b0);
    wait_valid();
    check("int_2_3", isum(obs_fi, 2, 3, 1'b0), 78);
    check("sq_2_3", isum(obs_fi, 2, 3, 1'b1), 650);
    check("int_1_1", isum(obs_fi, 1, 1, 1'b0), 14);
    check("sq_1_1", isum(obs_fi, 1, 1, 1'b1), 66);
    do_ack();

    // Same frame with pix_valid toggling
    send_frame(1, 1'b1);
    wait_valid();
    do_ack();

    // Non-sof pixels in IDLE are dropped
    async_reset();
    step();
    send(8'd7, 1'b0);
    send(8'd8, 1'b0);
    send(8'd9, 1'b0);
    step();

    // Restart mid-load
    for (int i = 0; i < 5; i++) send(8'(i + 1), i == 0);
    send(8'd99, 1'b1);
    for (int i = 1; i < NP; i++) send(8'(i + 1), 1'b0);
    wait_valid();
    do_ack();

    // Hold in READY with pixels offered
    send_frame(40, 1'b0);
    wait_valid();
    pix_valid = 1'b1;
    repeat (10) begin
      pix_data = 8'($urandom);
      pix_sof  = 1'($urandom);
      step();
    end
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    do_ack();
    step();

    // Async reset mid-LOAD, then mid-SETTLE
    for (int i = 0; i < 6; i++) send(8'(200 + i), i == 0);
    async_reset();
    step();
    send_frame(1, 1'b0);
    async_reset();
    step();
    send_frame(100, 1'b0);
    wait_valid();
    do_ack();

    // Single-cycle settle window
    use1 = 1'b1;
    m_settle = 1;
    async_reset();
    step();
    send_frame(1, 1'b0);
    wait_valid();
    check("s1_int_2_3", isum(obs_fi, 2, 3, 1'b0), 78);
    do_ack();
    step();

    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
